// File: rtl/graffiti_pixel_writer.sv
// graffiti_pixel_writer
// Maps IR-camera pen positions (1024x768) onto a 1bpp 640x480 framebuffer held
// in SRAM. Each accepted point becomes a read-modify-write of one 16-bit word.
// A full-frame clear can be requested and takes priority over queued points.
// SRAM traffic is only started while `enable` (write window) is high.
//
// Ports
//   clk, reset           system clock, synchronous active-low reset
//   cam_x, cam_y         camera coordinates, 1023 = no blob
//   cam_valid            1-cycle strobe, new coordinates
//   pen_erase            1 = clear pixel, 0 = set pixel (sampled with cam_valid)
//   clear_req            1-cycle strobe, blank whole framebuffer
//   enable               SRAM write window granted
//   address, data_write  SRAM word address / write data
//   read, write          SRAM requests, held until ready
//   data_read, ready     SRAM read data / 1-cycle completion strobe
//   busy                 work in flight, queued or pending
//   overflow             1-cycle pulse, point dropped because queue full
module graffiti_pixel_writer #(
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned WORDS_LINE = 40,
  parameter int unsigned LINES      = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  cam_x,
  input  logic [9:0]  cam_y,
  input  logic        cam_valid,
  input  logic        pen_erase,
  input  logic        clear_req,
  input  logic        enable,
  output logic [17:0] address,
  output logic [15:0] data_write,
  output logic        read,
  output logic        write,
  input  logic [15:0] data_read,
  input  logic        ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned MW = 13;
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned NW = $clog2(QDEPTH + 1);

  localparam logic [AW-1:0] CLR_LAST = AW'(WORDS_LINE * LINES - 1);
  localparam logic [CW-1:0] NO_BLOB  = CW'(1023);

  typedef struct packed {
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          erase;
  } point_t;

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, MODIFY, WR, WR_WAIT, CLR_WR, CLR_WAIT
  } state_t;

  state_t state, state_d;

  // Point queue and bookkeeping
  point_t        mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] count, count_d;
  point_t        head;
  point_t        last_pt;
  logic          last_valid, last_valid_d;
  logic          clear_pending, clear_pending_d;

  // Current RMW context
  logic [3:0]    cur_bit;
  logic          cur_erase;
  logic [DW-1:0] word_q;

  // Next values of the registered outputs
  logic [AW-1:0] address_d;
  logic [DW-1:0] data_write_d;
  logic          read_d, write_d, busy_d, overflow_d;

  // Capture path signals
  logic [CW-1:0] cap_px, cap_py;
  point_t        cap_pt;
  logic          no_blob, dup, cand, full, push, pop;
  logic          clr_active, clr_done, latch_word;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] mask, modified;

  // Scale 1024x768 camera space by 5/8 into 640x480 pixel space
  assign cap_px  = CW'((MW'(cam_x) * MW'(5)) >> 3);
  assign cap_py  = CW'((MW'(cam_y) * MW'(5)) >> 3);
  assign cap_pt  = '{px: cap_px, py: cap_py, erase: pen_erase};

  assign no_blob = (cam_x == NO_BLOB) || (cam_y == NO_BLOB);
  assign dup     = last_valid && (cap_pt == last_pt);
  assign cand    = cam_valid && !no_blob && !dup;
  assign full    = (count == NW'(QDEPTH));

  // Pop only from IDLE with the window open; a pending clear goes first
  assign pop     = (state == IDLE) && enable && !clear_pending && (count != '0);
  // A same-cycle pop frees a slot, so a full queue can still accept
  assign push    = cand && (!full || pop);

  assign head      = mem[rd_ptr];
  assign head_addr = AW'(head.py) * AW'(WORDS_LINE) + AW'(head.px[9:4]);

  assign clr_active = (state == CLR_WR) || (state == CLR_WAIT);
  assign clr_done   = (state == CLR_WAIT) && ready && (address == CLR_LAST);
  assign latch_word = ((state == RD) || (state == RD_WAIT)) && ready;

  // Leftmost pixel lives in the word MSB
  assign mask     = DW'(16'h8000) >> cur_bit;
  assign modified = cur_erase ? (word_q & ~mask) : (word_q | mask);

  // Queue occupancy and sticky flags
  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + NW'(1);
      2'b01:   count_d = count - NW'(1);
      default: count_d = count;
    endcase

    last_valid_d = last_valid;
    if (push)          last_valid_d = 1'b1;
    else if (clr_done) last_valid_d = 1'b0;

    clear_pending_d = clear_pending;
    if (clr_done)                       clear_pending_d = 1'b0;
    else if (clear_req && !clr_active)  clear_pending_d = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; ready is honoured in RD/WR too in case the SRAM answers at once
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (clear_pending && enable) state_d = CLR_WR;
        else if (pop)                state_d = RD;
      end
      RD:       state_d = ready ? MODIFY : RD_WAIT;
      RD_WAIT:  if (ready) state_d = MODIFY;
      MODIFY:   state_d = WR;
      WR:       state_d = ready ? IDLE : WR_WAIT;
      WR_WAIT:  if (ready) state_d = IDLE;
      CLR_WR:   if (enable) state_d = CLR_WAIT;
      CLR_WAIT: begin
        if (ready) state_d = (address == CLR_LAST) ? IDLE : CLR_WR;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: request lines follow the state being entered, so they
  // drop on the cycle after ready and read/write never overlap
  always_comb begin
    read_d       = (state_d == RD) || (state_d == RD_WAIT);
    write_d      = (state_d == WR) || (state_d == WR_WAIT) || (state_d == CLR_WAIT);
    address_d    = address;
    data_write_d = data_write;
    case (state)
      IDLE: begin
        if (state_d == RD)          address_d = head_addr;
        else if (state_d == CLR_WR) address_d = '0;
      end
      MODIFY:   data_write_d = modified;
      CLR_WR:   if (state_d == CLR_WAIT) data_write_d = '0;
      CLR_WAIT: if (state_d == CLR_WR)   address_d = address + AW'(1);
      default: ;
    endcase
    busy_d     = (state_d != IDLE) || (count_d != '0) || clear_pending_d;
    overflow_d = cand && full && !pop;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      address    <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      address    <= address_d;
      data_write <= data_write_d;
      read       <= read_d;
      write      <= write_d;
      busy       <= busy_d;
      overflow   <= overflow_d;
    end
  end

  // Queue control, filter memory and RMW context
  always_ff @(posedge clk) begin
    if (!reset) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      last_valid    <= 1'b0;
      last_pt       <= '0;
      clear_pending <= 1'b0;
      cur_bit       <= '0;
      cur_erase     <= 1'b0;
      word_q        <= '0;
    end else begin
      count         <= count_d;
      last_valid    <= last_valid_d;
      clear_pending <= clear_pending_d;
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        last_pt <= cap_pt;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        cur_bit   <= head.px[3:0];
        cur_erase <= head.erase;
      end
      if (latch_word) word_q <= data_read;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_pt;
  end

endmodule
